mpls_playlist_scheduler: RTL and testbench
==========================================

Name: mpls_playlist_scheduler

Overview:
- Time-sequences the LED sequencer through a programmable playlist.
- Each entry holds a pattern_sel code, a clk_selector rate and a duration in ticks.
- Sits between the configuration source and the sequencer top. It drives that top's pattern_sel, clk_selector and rstn inputs, so patterns change automatically with a clean restart on every change.

Parameters:
- DEPTH, 8, playlist entries (power of two, 2..64).
- AW, 3, log2(DEPTH).
- TICK_DIV, 10000000, clk_10MHz cycles per duration tick (default 1 s). Benches override with a small value.

Ports:
- clk_10MHz  in  1  system clock, 10 MHz.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  playlist write strobe.
- cfg_addr  in  AW  playlist write address.
- cfg_data  in  15  entry: [14:7] duration ticks, [6:5] clk_selector, [4:0] pattern_sel.
- cfg_len  in  AW+1  number of valid entries, 0..DEPTH.
- loop_en  in  1  1 = wrap to entry 0 after the last entry.
- start  in  1  single-cycle pulse: begin playback at entry 0.
- stop  in  1  single-cycle pulse: abort playback.
- pattern_sel  out  5  to sequencer pattern_sel.
- clk_selector  out  2  to sequencer clk_selector.
- seq_rstn  out  1  to sequencer rstn, active-low.
- entry_idx  out  AW  index of the entry currently playing.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-looping playlist finishes.

Behaviour:
- Reset values (all outputs registered): pattern_sel=0, clk_selector=0, seq_rstn=0, entry_idx=0, busy=0, done=0, state=IDLE. Playlist RAM is not reset.
- First cycle after rst deasserts: seq_rstn=1.
- Playlist RAM write: cfg_we writes cfg_data to cfg_addr on the clock edge, in any state.
  - A write to an entry takes effect the next time that entry is loaded. The entry currently playing is unaffected.
- FSM states: IDLE, LOAD, PLAY, ADVANCE.
- IDLE:
  - start=1 and cfg_len!=0 -> LOAD with idx=0.
  - start with cfg_len=0 is ignored.
- LOAD (1 cycle):
  - Read entry[idx] into pattern_sel, clk_selector and duration register; entry_idx=idx.
  - seq_rstn=0 for this single cycle, so the sequencer restarts with the new settings.
  - Clear tick divider and tick counter.
  - If duration==0 -> ADVANCE, else -> PLAY.
- PLAY:
  - seq_rstn=1.
  - Divider counts 0..TICK_DIV-1 and emits a tick on TICK_DIV-1.
  - The tick counter increments on each tick. When it reaches duration -> ADVANCE.
  - PLAY therefore lasts exactly duration*TICK_DIV cycles.
- ADVANCE (1 cycle):
  - idx+1 < cfg_len -> idx+1, LOAD.
  - Else if loop_en -> idx=0, LOAD.
  - Else -> IDLE with done=1 for one cycle.
- Latency:
  - start to first LOAD: 1 cycle.
  - Outputs for an entry are valid from the cycle after LOAD.
  - Entry-to-entry gap: ADVANCE + LOAD = 2 cycles.
- stop: in any non-IDLE state -> IDLE next cycle.
  - pattern_sel, clk_selector and entry_idx hold their last values; seq_rstn=1; done=0.
  - stop together with start in IDLE: stop wins and start is ignored.
- start while busy: ignored.
- cfg_len and loop_en are sampled only in ADVANCE. If cfg_len is lowered below idx+1 mid-run, the end-of-list condition is taken at the next ADVANCE.
- All entries with duration 0 and loop_en=1: the block cycles LOAD/ADVANCE indefinitely. This is legal and is exited by stop or rst.
- busy = (state != IDLE).
- rst mid-operation: all state and outputs return to their reset values on the next edge.

Optional Feature:
- Macro MPLS_SCHED_PAUSE_EN adds input port pause (1 bit).
  - With the macro: while pause=1 in PLAY, the divider and tick counter freeze and outputs hold. Release resumes with no lost or extra cycles. pause has no effect in LOAD, ADVANCE or IDLE.
  - Without the macro: the port does not exist and PLAY always counts.

Test Plan:
- Basic run (TICK_DIV=4): write entries 0={dur 2, clk 1, pat 3} and 1={dur 1, clk 2, pat 7}; cfg_len=2, loop_en=0; pulse start.
  - Expect seq_rstn low one cycle, then pat=3/clk=1 for 8 cycles.
  - Then a 2-cycle gap, then pat=7/clk=2 for 4 cycles.
  - Then done pulse and busy=0.
- Loop wrap: same playlist with loop_en=1.
  - After entry 1, entry_idx returns to 0 and pat=3 reappears.
  - busy stays 1 and done is never asserted.
- Zero duration: entry 1 duration=0, cfg_len=3.
  - Entry 1 is skipped: no PLAY cycles, seq_rstn pulses once for its LOAD.
  - Entry 2 follows entry 0 after a 4-cycle gap.
- Stop mid-PLAY of entry 0: -> IDLE next cycle, pat=3 held, seq_rstn=1, done=0.
  - start and stop in the same IDLE cycle -> busy remains 0.
- Edge cases: cfg_len=0 with start -> busy stays 0. Write entry 0 during its PLAY -> new value appears only on the next loop.
  - Assert rst mid-PLAY -> all outputs 0 next cycle; seq_rstn=1 the following cycle.
- With MPLS_SCHED_PAUSE_EN: pause for 5 cycles mid-PLAY of a 2-tick entry (TICK_DIV=4) -> entry duration is 13 cycles; outputs are unchanged during the pause.

Source files
------------

// File: rtl/mpls_playlist_scheduler.sv
// Playlist scheduler: steps the LED sequencer through a RAM of {duration, clk_selector, pattern_sel}
// entries, pulsing seq_rstn low on each load. Define MPLS_SCHED_PAUSE_EN to add the pause input.
module mpls_playlist_scheduler #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int TICK_DIV = 10000000
) (
  input  logic          clk_10MHz,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [14:0]   cfg_data,
  input  logic [AW:0]   cfg_len,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
`ifdef MPLS_SCHED_PAUSE_EN
  input  logic          pause,
`endif
  output logic [4:0]    pattern_sel,
  output logic [1:0]    clk_selector,
  output logic          seq_rstn,
  output logic [AW-1:0] entry_idx,
  output logic          busy,
  output logic          done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] PLAY    = 2'd2;
  localparam logic [1:0] ADVANCE = 2'd3;

  logic [14:0]      mem [DEPTH];
  logic [1:0]       state_reg;
  logic [AW-1:0]    idx_reg;
  logic [7:0]       dur_reg;
  logic [7:0]       tick_cnt_reg;
  logic [DIV_W-1:0] div_reg;
  logic [14:0]      rd_entry;
  logic [AW:0]      idx_inc;
  logic             play_hold;

  // Writes are accepted in every state; the playing entry keeps its registered copy.
  always_ff @(posedge clk_10MHz) begin
    if (cfg_we) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  assign rd_entry = mem[idx_reg];
  assign idx_inc  = {1'b0, idx_reg} + {{AW{1'b0}}, 1'b1};

`ifdef MPLS_SCHED_PAUSE_EN
  assign play_hold = pause;
`else
  assign play_hold = 1'b0;
`endif

  always_ff @(posedge clk_10MHz) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      dur_reg      <= '0;
      tick_cnt_reg <= '0;
      div_reg      <= '0;
      pattern_sel  <= '0;
      clk_selector <= '0;
      seq_rstn     <= 1'b0;
      entry_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      seq_rstn <= 1'b1;
      if (stop && state_reg != IDLE) begin
        // Abort keeps the last pattern on the sequencer outputs.
        state_reg <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !stop && cfg_len != '0) begin
              idx_reg   <= '0;
              seq_rstn  <= 1'b0;
              busy      <= 1'b1;
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            pattern_sel  <= rd_entry[4:0];
            clk_selector <= rd_entry[6:5];
            dur_reg      <= rd_entry[14:7];
            entry_idx    <= idx_reg;
            div_reg      <= '0;
            tick_cnt_reg <= '0;
            state_reg    <= (rd_entry[14:7] == 8'd0) ? ADVANCE : PLAY;
          end
          PLAY: begin
            if (!play_hold) begin
              if (div_reg == DIV_LAST) begin
                div_reg      <= '0;
                tick_cnt_reg <= tick_cnt_reg + 8'd1;
                if (tick_cnt_reg + 8'd1 == dur_reg) begin
                  state_reg <= ADVANCE;
                end
              end else begin
                div_reg <= div_reg + 1'b1;
              end
            end
          end
          ADVANCE: begin
            if (idx_inc < cfg_len) begin
              idx_reg   <= idx_reg + 1'b1;
              seq_rstn  <= 1'b0;
              state_reg <= LOAD;
            end else if (loop_en) begin
              idx_reg   <= '0;
              seq_rstn  <= 1'b0;
              state_reg <= LOAD;
            end else begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpls_playlist_scheduler.sv
// Self-checking bench for mpls_playlist_scheduler: cycle-count reference model plus directed
// literal checks and a randomized phase. Exercises pause when MPLS_SCHED_PAUSE_EN is defined.
module tb_mpls_playlist_scheduler;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TD    = 4;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_PLAY = 2;
  localparam int P_ADV  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [14:0]   cfg_data = '0;
  logic [AW:0]   cfg_len = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;

  logic [4:0]    pattern_sel;
  logic [1:0]    clk_selector;
  logic          seq_rstn;
  logic [AW-1:0] entry_idx;
  logic          busy;
  logic          done;

  mpls_playlist_scheduler #(.DEPTH(DEPTH), .AW(AW), .TICK_DIV(TD)) dut (
    .clk_10MHz   (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_len     (cfg_len),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
`ifdef MPLS_SCHED_PAUSE_EN
    .pause       (pause),
`endif
    .pattern_sel (pattern_sel),
    .clk_selector(clk_selector),
    .seq_rstn    (seq_rstn),
    .entry_idx   (entry_idx),
    .busy        (busy),
    .done        (done)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a playing entry simply lasts duration*TD unpaused cycles.
  logic [14:0]   m_mem [DEPTH];
  int            m_phase = P_IDLE;
  int            m_left = 0;
  int            m_idx = 0;
  logic [4:0]    m_pat = '0;
  logic [1:0]    m_clk = '0;
  logic          m_rstn = 1'b0;
  logic [AW-1:0] m_eidx = '0;
  logic          m_done = 1'b0;
  logic          m_valid = 1'b0;
  logic [14:0]   m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_pat = '0; m_clk = '0; m_rstn = 1'b0;
      m_eidx = '0; m_done = 1'b0; m_idx = 0; m_left = 0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      m_rstn = 1'b1;
      if (stop && m_phase != P_IDLE) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_IDLE) begin
        if (start && !stop && cfg_len != 0) begin
          m_idx = 0; m_phase = P_LOAD; m_rstn = 1'b0;
        end
      end else if (m_phase == P_LOAD) begin
        m_e    = m_mem[m_idx];
        m_pat  = m_e[4:0];
        m_clk  = m_e[6:5];
        m_eidx = AW'(m_idx);
        m_left = int'(m_e[14:7]) * TD;
        m_phase = (m_left == 0) ? P_ADV : P_PLAY;
      end else if (m_phase == P_PLAY) begin
        if (!pause) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_ADV;
        end
      end else begin
        if (m_idx + 1 < int'(cfg_len)) begin
          m_idx = m_idx + 1; m_phase = P_LOAD; m_rstn = 1'b0;
        end else if (loop_en) begin
          m_idx = 0; m_phase = P_LOAD; m_rstn = 1'b0;
        end else begin
          m_phase = P_IDLE; m_done = 1'b1;
        end
      end
    end
    if (cfg_we) m_mem[cfg_addr] = cfg_data;
  end

  logic [12:0] cmp_act;
  logic [12:0] cmp_exp;

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_act = {pattern_sel, clk_selector, seq_rstn, entry_idx, busy, done};
      cmp_exp = {m_pat, m_clk, m_rstn, m_eidx, (m_phase != P_IDLE), m_done};
      check("model", {19'd0, cmp_act}, {19'd0, cmp_exp});
    end
  end

  logic [4:0]    cap_pat  [0:40];
  logic [1:0]    cap_clk  [0:40];
  logic          cap_rstn [0:40];
  logic [AW-1:0] cap_eidx [0:40];
  logic          cap_busy [0:40];
  logic          cap_done [0:40];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int dur, input int cs, input int pat);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = {8'(dur), 2'(cs), 5'(pat)};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // cap[k] holds the outputs after the k-th edge counted from the edge that sampled start.
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_pat[k] = pattern_sel; cap_clk[k] = clk_selector; cap_rstn[k] = seq_rstn;
      cap_eidx[k] = entry_idx; cap_busy[k] = busy; cap_done[k] = done;
    end
  endtask

  int  zero_cnt;
  bit  saw_done, busy_drop, seen_e1, wrapped, found_new, early_change;
  int  first7;

  initial begin
    // Reset
    tick(); tick();
    check("rst_pat", pattern_sel, 0);
    check("rst_rstn", seq_rstn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("rstn_after_rst", seq_rstn, 1);
    $display("test reset complete");

    for (int i = 0; i < DEPTH; i++) wr(i, i % 3, i % 4, i + 8);
    wr(0, 2, 1, 3);
    wr(1, 1, 2, 7);
    wr(2, 1, 3, 5);
    cfg_len = 4'd2;
    loop_en = 1'b0;
    tick();

    // Basic run
    pulse_start();
    capture(18);
    check("basic_load_rstn", cap_rstn[1], 0);
    check("basic_load_busy", cap_busy[1], 1);
    check("basic_e0_pat", cap_pat[2], 3);
    check("basic_e0_clk", cap_clk[2], 1);
    check("basic_e0_rstn", cap_rstn[2], 1);
    check("basic_e0_last", cap_pat[9], 3);
    check("basic_gap_load", cap_rstn[11], 0);
    check("basic_e1_pat", cap_pat[12], 7);
    check("basic_e1_clk", cap_clk[12], 2);
    check("basic_e1_idx", cap_eidx[12], 1);
    check("basic_last_busy", cap_busy[16], 1);
    check("basic_done", cap_done[17], 1);
    check("basic_idle", cap_busy[17], 0);
    check("basic_done_pulse", cap_done[18], 0);
    $display("test basic complete");

    // Loop wrap
    tick();
    loop_en = 1'b1;
    pulse_start();
    saw_done = 0; busy_drop = 0; seen_e1 = 0; wrapped = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) saw_done = 1;
      if (!busy) busy_drop = 1;
      if (entry_idx == 1) seen_e1 = 1;
      if (seen_e1 && entry_idx == 0 && pattern_sel == 3) wrapped = 1;
    end
    check("loop_no_done", saw_done, 0);
    check("loop_busy", busy_drop, 0);
    check("loop_wrap", wrapped, 1);
    pulse_stop();
    check("loop_stopped", busy, 0);
    loop_en = 1'b0;
    $display("test loop complete");

    // Zero-duration entry is skipped
    wr(1, 0, 2, 7);
    cfg_len = 4'd3;
    tick();
    pulse_start();
    capture(20);
    zero_cnt = 0;
    for (int k = 1; k <= 20; k++) if (cap_rstn[k] == 1'b0) zero_cnt++;
    check("zero_rstn_pulses", zero_cnt, 3);
    check("zero_skip_idx", cap_eidx[12], 1);
    check("zero_load2", cap_rstn[13], 0);
    check("zero_e2_pat", cap_pat[14], 5);
    check("zero_e2_idx", cap_eidx[14], 2);
    check("zero_done", cap_done[19], 1);
    wr(1, 1, 2, 7);
    cfg_len = 4'd2;
    tick();
    $display("test zero_duration complete");

    // Stop mid-play, then start+stop together
    pulse_start();
    tick(); tick(); tick(); tick();
    pulse_stop();
    check("stop_busy", busy, 0);
    check("stop_pat", pattern_sel, 3);
    check("stop_rstn", seq_rstn, 1);
    check("stop_done", done, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    tick();
    check("start_stop_busy2", busy, 0);
    $display("test stop complete");

    // Empty playlist
    cfg_len = 4'd0;
    pulse_start();
    check("len0_busy", busy, 0);
    tick();
    check("len0_busy2", busy, 0);
    cfg_len = 4'd2;
    $display("test empty complete");

    // Rewrite entry 0 while it plays
    loop_en = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    wr(0, 1, 1, 9);
    found_new = 0; early_change = 0; seen_e1 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (entry_idx == 1) seen_e1 = 1;
      if (!seen_e1 && pattern_sel != 3) early_change = 1;
      if (seen_e1 && entry_idx == 0 && pattern_sel == 9) found_new = 1;
    end
    check("rewrite_hold", early_change, 0);
    check("rewrite_next", found_new, 1);
    pulse_stop();
    loop_en = 1'b0;
    wr(0, 2, 1, 3);
    $display("test rewrite complete");

    // Reset mid-play
    pulse_start();
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pat", pattern_sel, 0);
    check("midrst_clk", clk_selector, 0);
    check("midrst_rstn", seq_rstn, 0);
    check("midrst_busy", busy, 0);
    tick();
    check("midrst_rstn_next", seq_rstn, 1);
    $display("test mid_reset complete");

`ifdef MPLS_SCHED_PAUSE_EN
    // Pause 5 cycles inside a 2-tick entry: 13 play cycles, next entry at edge 17
    pulse_start();
    tick(); tick(); tick();
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("pause_hold_pat", pattern_sel, 3);
      check("pause_hold_rstn", seq_rstn, 1);
    end
    pause = 1'b0;
    first7 = -1;
    for (int e = 10; e < 40; e++) begin
      tick();
      if (first7 < 0 && pattern_sel == 7) first7 = e;
    end
    check("pause_entry_len", first7, 17);
    $display("test pause complete");
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_data = {8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      start = ($urandom_range(0, 14) == 0);
      stop = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 32) == 0) cfg_len = 4'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 32) == 0) loop_en = ~loop_en;
`ifdef MPLS_SCHED_PAUSE_EN
      pause = ($urandom_range(0, 4) == 0);
`endif
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0; rst = 1'b0; pause = 1'b0;
    pulse_stop();
    tick(); tick();
    $display("test random complete");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
